seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Time-multiplexed driver for an 8-digit common-anode seven-segment display. Sits directly downstream of the 32-bit binary-to-hex digit splitter and consumes its eight 4-bit digits.
- Snapshots the digits once per frame to avoid tearing. Scans the anodes one slot at a time with a blanking guard against ghosting.
- Decodes each hex digit to active-low segments. Supports optional leading-zero blanking, per-digit enables and decimal points.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dig0..dig7  in  4 each  hex digits; dig0 is least significant, rightmost.
- digit_en  in  8  bit k=1 enables digit k.
- dp_in  in  8  bit k=1 lights the decimal point of digit k.
- lz_blank  in  1  leading-zero blanking enable.
- anode_n  out  8  active-low anode selects; bit k drives digit k.
- seg_n  out  7  active-low segments; bit6=g … bit0=a.
- dp_n  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse at the end of each full 8-digit frame.

Behaviour:
- Reset (async, active-high): pre=0, idx=0, snapshot=0, anode_n=8'hFF, seg_n=7'h7F, dp_n=1, frame_tick=0. Reset asserted mid-frame aborts the scan immediately. The first cycle after release restarts at slot 0 with a fresh snapshot.
- Prescaler pre:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the edge where pre==REFRESH_DIV-1, idx increments, wrapping 7->0.
  - Frame length = 8*REFRESH_DIV cycles.
- Snapshot:
  - On the edge where pre==0 && idx==0, capture dig0..dig7, digit_en, dp_in and lz_blank. This includes the first cycle after reset.
  - Input changes at any other time have no effect until the next frame.
- Leading-zero blanking (from snapshot): if lz_blank=1, digit k (k>=1) is suppressed when snapshot digits k..7 are all zero. Digit 0 is never suppressed by LZB.
- Outputs are registered and lag the pre/idx/snapshot state by one clock. Each edge computes from the pre-edge state:
  - Slot visible = pre >= BLANK_CYCLES AND digit_en[idx] AND not LZB-suppressed(idx).
  - If visible: anode_n = ~(8'b1<<idx), seg_n = decode(snap_dig[idx]), dp_n = ~dp[idx].
  - Otherwise: anode_n=8'hFF, seg_n=7'h7F, dp_n=1.
- Decode (seg_n hex, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- frame_tick: high for exactly one cycle following the edge where pre==REFRESH_DIV-1 && idx==7.
- Blank guard: a snapshot load coincides with a blanked slot-0 cycle, so a stale value is never driven.
- At most one anode is low in any cycle.

Test Plan:
- Common bench settings: REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset check: assert rst mid-slot -> anode_n=FF, seg_n=7F, dp_n=1, frame_tick=0 asynchronously, with no clock edge. After release, digit 0 is first lit 2 cycles later.
- Scan order: digits 0x89ABCDEF, digit_en=FF, lz_blank=0:
  - anode_n cycles FE,FD,…,7F, each low for 3 of every 4 cycles.
  - seg_n sequence is 0E,06,21,46,03,08,10,00.
  - frame_tick pulses every 32 cycles.
- Leading-zero blanking: value 0x00000305, lz_blank=1 -> digits 0..2 lit (seg 12,40,30). Digits 3..7 keep anode_n=FF. Value 0 -> only digit 0 lit showing 40.
- Tearing: change digits mid-frame (idx=3) -> remaining slots still show the old snapshot. The new value appears from slot 0 of the next frame.
- Enables and decimal points: digit_en=0xF0, dp_in=0x10 -> digits 0..3 never lit. dp_n=0 only while anode_n=EF.
- Boundary sizing: REFRESH_DIV=2, BLANK_CYCLES=1 -> each digit is lit exactly 1 cycle per slot. frame_tick period is 16 and never two cycles wide.

Source files
------------

// File: rtl/seg7_scan_mux_if.sv
// Digit/display bundle between the hex digit splitter, the scan multiplexer and the display pins.
// There is no valid/ready handshake. The digit-side signals are level inputs that the scanner
// samples once per frame, and the display-side signals are registered outputs.
interface seg7_scan_mux_if;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dig4;
    logic [3:0] dig5;
    logic [3:0] dig6;
    logic [3:0] dig7;
    logic [7:0] digit_en;
    logic [7:0] dp_in;
    logic       lz_blank;
    logic [7:0] anode_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_tick;

    modport master (
        output dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
        output digit_en, dp_in, lz_blank,
        input  anode_n, seg_n, dp_n, frame_tick
    );

    modport slave (
        input  dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
        input  digit_en, dp_in, lz_blank,
        output anode_n, seg_n, dp_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Eight-digit common-anode seven-segment scanner. It takes a per-frame snapshot of the digits,
// blanks the start of every slot, and supports leading-zero blanking, digit enables and decimal points.
module seg7_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_mux_if.slave    bus
);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_V = PRE_W'(BLANK_CYCLES);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_dig_q, snap_dig_d;
    logic [7:0]       snap_en_q, snap_en_d;
    logic [7:0]       snap_dp_q, snap_dp_d;
    logic             snap_lz_q, snap_lz_d;
    logic [7:0]       anode_n_q, anode_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic [31:0] dig_all;
    logic [7:0]  suppress;
    logic [3:0]  cur_dig;
    logic        visible;

    assign dig_all = {bus.dig7, bus.dig6, bus.dig5, bus.dig4,
                      bus.dig3, bus.dig2, bus.dig1, bus.dig0};

    // Digit k is dark under LZB when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        for (int k = 7; k >= 1; k--) begin
            zero_run    = zero_run & (snap_dig_q[4*k +: 4] == 4'd0);
            suppress[k] = snap_lz_q & zero_run;
        end
    end

    assign cur_dig = snap_dig_q[{idx_q, 2'b00} +: 4];
    assign visible = (pre_q >= BLANK_V) && snap_en_q[idx_q] && !suppress[idx_q];

    always_comb begin
        pre_d        = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        idx_d        = (pre_q == PRE_MAX) ? idx_q + 3'd1 : idx_q;
        snap_dig_d   = snap_dig_q;
        snap_en_d    = snap_en_q;
        snap_dp_d    = snap_dp_q;
        snap_lz_d    = snap_lz_q;
        anode_n_d    = 8'hFF;
        seg_n_d      = 7'h7F;
        dp_n_d       = 1'b1;
        frame_tick_d = (pre_q == PRE_MAX) && (idx_q == 3'd7);

        // This cycle is always blanked because pre_q is 0, so the new snapshot is never shown stale.
        if (pre_q == '0 && idx_q == 3'd0) begin
            snap_dig_d = dig_all;
            snap_en_d  = bus.digit_en;
            snap_dp_d  = bus.dp_in;
            snap_lz_d  = bus.lz_blank;
        end

        if (visible) begin
            anode_n_d = ~(8'd1 << idx_q);
            dp_n_d    = ~snap_dp_q[idx_q];
            case (cur_dig)
                4'h0: seg_n_d = 7'h40;
                4'h1: seg_n_d = 7'h79;
                4'h2: seg_n_d = 7'h24;
                4'h3: seg_n_d = 7'h30;
                4'h4: seg_n_d = 7'h19;
                4'h5: seg_n_d = 7'h12;
                4'h6: seg_n_d = 7'h02;
                4'h7: seg_n_d = 7'h78;
                4'h8: seg_n_d = 7'h00;
                4'h9: seg_n_d = 7'h10;
                4'hA: seg_n_d = 7'h08;
                4'hB: seg_n_d = 7'h03;
                4'hC: seg_n_d = 7'h46;
                4'hD: seg_n_d = 7'h21;
                4'hE: seg_n_d = 7'h06;
                default: seg_n_d = 7'h0E;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_en_q    <= '0;
            snap_dp_q    <= '0;
            snap_lz_q    <= 1'b0;
            anode_n_q    <= 8'hFF;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_en_q    <= snap_en_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            anode_n_q    <= anode_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.anode_n    = anode_n_q;
    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux. It runs two instances (REFRESH_DIV 4 and 2, BLANK_CYCLES 1) against a
// cycle-count model that derives slot, digit and snapshot from the elapsed cycles.
module tb_seg7_scan_mux;
  localparam int BLANK = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_mux_if bus_a ();
  seg7_scan_mux_if bus_b ();

  seg7_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(BLANK)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  seg7_scan_mux #(.REFRESH_DIV(2), .BLANK_CYCLES(BLANK)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic [31:0] value = 32'h0;
  logic [7:0]  en = 8'h00;
  logic [7:0]  dp = 8'h00;
  logic        lz = 1'b0;

  assign bus_a.dig0 = value[3:0];    assign bus_b.dig0 = value[3:0];
  assign bus_a.dig1 = value[7:4];    assign bus_b.dig1 = value[7:4];
  assign bus_a.dig2 = value[11:8];   assign bus_b.dig2 = value[11:8];
  assign bus_a.dig3 = value[15:12];  assign bus_b.dig3 = value[15:12];
  assign bus_a.dig4 = value[19:16];  assign bus_b.dig4 = value[19:16];
  assign bus_a.dig5 = value[23:20];  assign bus_b.dig5 = value[23:20];
  assign bus_a.dig6 = value[27:24];  assign bus_b.dig6 = value[27:24];
  assign bus_a.dig7 = value[31:28];  assign bus_b.dig7 = value[31:28];
  assign bus_a.digit_en = en;        assign bus_b.digit_en = en;
  assign bus_a.dp_in = dp;           assign bus_b.dp_in = dp;
  assign bus_a.lz_blank = lz;        assign bus_b.lz_blank = lz;

  int n_checks = 0;
  int n_fails = 0;

  // Reference model state: cycles since reset release plus each instance's latched frame contents.
  int          t;
  int          divs [2] = '{4, 2};
  logic [31:0] sv [2];
  logic [7:0]  se [2];
  logic [7:0]  sd [2];
  logic        sl [2];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0]  ea [2];
  logic [6:0]  es [2];
  logic        ed [2];
  logic        ef [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int m = 0; m < 2; m++) begin
      sv[m] = '0; se[m] = '0; sd[m] = '0; sl[m] = 1'b0;
    end
  endtask

  task automatic check_reset_state();
    check("rst_anode_a", bus_a.anode_n, 8'hFF);
    check("rst_seg_a", bus_a.seg_n, 7'h7F);
    check("rst_dp_a", bus_a.dp_n, 1'b1);
    check("rst_tick_a", bus_a.frame_tick, 1'b0);
    check("rst_anode_b", bus_b.anode_n, 8'hFF);
    check("rst_seg_b", bus_b.seg_n, 7'h7F);
    check("rst_dp_b", bus_b.dp_n, 1'b1);
    check("rst_tick_b", bus_b.frame_tick, 1'b0);
  endtask

  // One clock edge: predict both instances' outputs, latch a new frame if due, then compare.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      int   pre;
      int   idx;
      logic vis;
      pre = t % divs[m];
      idx = (t / divs[m]) % 8;
      vis = (pre >= BLANK) && se[m][idx] && !(sl[m] && idx >= 1 && (sv[m] >> (4 * idx)) == 32'd0);
      ea[m] = vis ? ~(8'd1 << idx) : 8'hFF;
      es[m] = vis ? seg_tab[(sv[m] >> (4 * idx)) & 32'hF] : 7'h7F;
      ed[m] = vis ? ~sd[m][idx] : 1'b1;
      ef[m] = (pre == divs[m] - 1) && (idx == 7);
      if (t % (8 * divs[m]) == 0) begin
        sv[m] = value; se[m] = en; sd[m] = dp; sl[m] = lz;
      end
    end
    t++;
    @(posedge clk);
    #1;
    check("anode_a", bus_a.anode_n, ea[0]);
    check("seg_a", bus_a.seg_n, es[0]);
    check("dp_a", bus_a.dp_n, ed[0]);
    check("tick_a", bus_a.frame_tick, ef[0]);
    check("anode_b", bus_b.anode_n, ea[1]);
    check("seg_b", bus_b.seg_n, es[1]);
    check("dp_b", bus_b.dp_n, ed[1]);
    check("tick_b", bus_b.frame_tick, ef[1]);
  endtask

  initial begin
    value = 32'h89ABCDEF; en = 8'hFF; dp = 8'h00; lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    model_reset();

    // Digit 0 lights on the second edge after release.
    tick();
    check("first_edge_blank", bus_a.anode_n, 8'hFF);
    tick();
    check("second_edge_lit", bus_a.anode_n, 8'hFE);
    check("second_edge_seg", bus_a.seg_n, 7'h0E);

    // Scan order over two frames.
    repeat (62) tick();

    // Leading-zero blanking, then an all-zero value.
    value = 32'h00000305; lz = 1'b1;
    repeat (64) tick();
    value = 32'h0;
    repeat (64) tick();

    // Tearing: change the digits while the long-slot instance scans slot 3.
    value = 32'h12345678; lz = 1'b0;
    repeat (32) tick();
    for (int g = 0; g < 40 && (t % 32) != 12; g++) tick();
    check("tear_slot3", (t / 4) % 8, 3);
    value = 32'hFEDCBA98;
    repeat (52) tick();

    // Enables and decimal points.
    en = 8'hF0; dp = 8'h10;
    repeat (32) tick();
    for (int i = 0; i < 32; i++) begin
      tick();
      check("low_digits_dark", bus_a.anode_n[3:0], 4'hF);
    end

    // Asynchronous reset part-way through a slot.
    en = 8'hFF; dp = 8'h55;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    model_reset();
    repeat (40) tick();

    // Random frames with inputs changing at random times.
    for (int r = 0; r < 14; r++) begin
      value = $urandom();
      if ($urandom_range(0, 2) == 0) value = value >> (4 * $urandom_range(1, 8));
      en = 8'($urandom_range(0, 255));
      dp = 8'($urandom_range(0, 255));
      lz = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
